d_branch_sched: RTL

- D-stage branch scheduler for the 5-stage MIPS pipeline.
- Tracks in-flight register writers in E/M/W with a small scoreboard.
- Selects the forwarding source for each operand of the D-stage equality comparator.
- Stalls a branch until both operands are forwardable, then resolves beq/bne taken from the comparator's equal flag.
- Sits beside the D-stage comparator; drives its operand muxes and the F/D stall and redirect logic.

---
 rtl/d_branch_sched.sv | 98 +++++++++
 1 files changed

// File: rtl/d_branch_sched.sv
// D-stage branch scheduler: E/M/W writer scoreboard, comparator operand forwarding,
// branch stall and beq/bne resolution.
module d_branch_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_br,
  input  logic             d_br_ne,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_wr_en,
  input  logic [4:0]       d_wr_addr,
  input  logic [1:0]       d_tnew,
  input  logic             flush,
  input  logic             cmp_eq,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             br_taken,
  output logic             br_resolved,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       vld;
    logic [4:0] addr;
    logic [1:0] tnew;
  } sb_entry_t;

  sb_entry_t        e_q, m_q, w_q;
  sb_entry_t        e_d, m_d, w_d;
  sb_entry_t        e_v, m_v, w_v;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_wait, rt_wait;

  function automatic sb_entry_t age_entry(input sb_entry_t s);
    sb_entry_t r;
    r = s;
    if (s.tnew != 2'd0) r.tnew = s.tnew - 2'd1;
    return r;
  endfunction

  // Returns {wait, sel}: nearest producer wins; a not-yet-ready one forces RF plus wait.
  function automatic logic [2:0] resolve_src(input logic [4:0] r, input sb_entry_t e,
                                             input sb_entry_t m, input sb_entry_t w);
    logic [2:0] res;
    res = 3'b000;
    if (r != 5'd0) begin
      if (e.vld && e.addr == r)      res = (e.tnew == 2'd0) ? 3'b001 : 3'b100;
      else if (m.vld && m.addr == r) res = (m.tnew == 2'd0) ? 3'b010 : 3'b100;
      else if (w.vld && w.addr == r) res = (w.tnew == 2'd0) ? 3'b011 : 3'b100;
    end
    return res;
  endfunction

  // Outputs see an empty scoreboard while reset is held.
  always_comb begin
    e_v = reset ? '0 : e_q;
    m_v = reset ? '0 : m_q;
    w_v = reset ? '0 : w_q;
    {rs_wait, fwd_rs_sel} = resolve_src(d_rs, e_v, m_v, w_v);
    {rt_wait, fwd_rt_sel} = resolve_src(d_rt, e_v, m_v, w_v);
    stall       = d_br & (rs_wait | rt_wait);
    br_resolved = d_br & ~stall & ~flush;
    br_taken    = br_resolved & (cmp_eq ^ d_br_ne);
  end

  always_comb begin
    e_d = '0;
    if (!(flush || stall)) begin
      e_d.vld  = d_wr_en & (d_wr_addr != 5'd0);
      e_d.addr = d_wr_addr;
      e_d.tnew = (d_tnew == 2'd3) ? 2'd2 : d_tnew;
    end
    m_d   = age_entry(e_q);
    w_d   = age_entry(m_q);
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
